// File: rtl/symsync_timing_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : symsync_timing_ctrl
// Description : Symbol timing recovery: mod-1 NCO strobe/uk generator, Gardner
//               TED and shift-gain PI loop filter. Optional lock detector is
//               built when SYMSYNC_LOCK_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module symsync_timing_ctrl #(
    parameter int SYM_WIDTH  = 1,
    parameter int INT_WIDTH  = 1,
    parameter int DEC_WIDTH  = 14,
    parameter int DATA_WIDTH = SYM_WIDTH + INT_WIDTH + DEC_WIDTH,
    parameter int W_NOM      = 2 ** (DEC_WIDTH - 1),
    parameter int KP_SHIFT   = 4,
    parameter int KI_SHIFT   = 8,
    parameter int LOCK_THR   = 2 ** (DEC_WIDTH - 4),
    parameter int LOCK_CNT   = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         sample_valid,
    input  logic                         interp_valid,
    input  logic signed [DATA_WIDTH-1:0] interpI,
    input  logic signed [DATA_WIDTH-1:0] interpQ,
    output logic                         data_ready,
    output logic        [DATA_WIDTH-1:0] uk,
    output logic                         sym_valid,
    output logic signed [DATA_WIDTH-1:0] symI,
    output logic signed [DATA_WIDTH-1:0] symQ,
    output logic signed [DATA_WIDTH-1:0] ted_err,
    output logic                         lock
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH + 2;

    localparam logic [0:0] PH_ON  = 1'b0;
    localparam logic [0:0] PH_MID = 1'b1;

    localparam logic        [DEC_WIDTH-1:0] C_ETA_MAX = '1;
    localparam logic        [DEC_WIDTH-1:0] C_W_NOM   = DEC_WIDTH'(W_NOM);
    localparam logic signed [PW-1:0]        C_E_MAX   = PW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [PW-1:0]        C_E_MIN   = PW'(-(64'sd1 <<< (DW - 1)));
    localparam logic signed [DW:0]          C_LIM     = (DW + 1)'(64'sd1 <<< (DEC_WIDTH - 2));
    localparam logic signed [DW:0]          C_LIM_N   = -C_LIM;

    logic        [DEC_WIDTH-1:0] eta_q, eta_d, w_q, w_d;
    logic                        dr_q, dr_d;
    logic        [DW-1:0]        uk_q, uk_d;
    logic        [0:0]           phase_q, phase_d;
    logic                        first_q, first_d;
    logic signed [DW-1:0]        prevI_q, prevI_d, prevQ_q, prevQ_d;
    logic signed [DW-1:0]        midI_q, midI_d, midQ_q, midQ_d;
    logic                        symv_q, symv_d;
    logic signed [DW-1:0]        symI_q, symI_d, symQ_q, symQ_d;
    logic signed [DW-1:0]        ted_q, ted_d;
    logic                        ted_upd_q, ted_upd_d;
    logic signed [DW-1:0]        acc_q, acc_d;

    function automatic logic signed [DW:0] sat_lim(input logic signed [DW:0] x);
        if (x > C_LIM)   return C_LIM;
        if (x < C_LIM_N) return C_LIM_N;
        return x;
    endfunction

    // One guard bit: a negative t flags the modulo-1 underflow.
    logic signed [DEC_WIDTH:0] w_t;
    logic        [DW-1:0]      w_uk_next;
    assign w_t       = $signed({1'b0, eta_q}) - $signed({1'b0, w_q});
    assign w_uk_next = eta_q[DEC_WIDTH-1] ? DW'(C_ETA_MAX) : DW'({eta_q[DEC_WIDTH-2:0], 1'b0});

    logic signed [PW-1:0] w_mulI, w_mulQ, w_esh;
    logic signed [DW-1:0] w_e;
    logic                 w_ted_fire;
    assign w_mulI     = PW'(midI_q) * (PW'(interpI) - PW'(prevI_q));
    assign w_mulQ     = PW'(midQ_q) * (PW'(interpQ) - PW'(prevQ_q));
    assign w_esh      = (w_mulI + w_mulQ) >>> DEC_WIDTH;
    assign w_e        = (w_esh > C_E_MAX) ? DW'(C_E_MAX) :
                        (w_esh < C_E_MIN) ? DW'(C_E_MIN) : DW'(w_esh);
    assign w_ted_fire = interp_valid && (phase_q == PH_ON) && !first_q;

    logic signed [DW:0] w_acc_new, w_v, w_w_new;
    assign w_acc_new = sat_lim((DW + 1)'(acc_q) + (DW + 1)'(ted_q >>> KI_SHIFT));
    assign w_v       = sat_lim((DW + 1)'(ted_q >>> KP_SHIFT) + w_acc_new);
    assign w_w_new   = (DW + 1)'(W_NOM) + w_v;

    always_comb begin
        eta_d     = eta_q;
        w_d       = w_q;
        dr_d      = 1'b0;
        uk_d      = uk_q;
        phase_d   = phase_q;
        first_d   = first_q;
        prevI_d   = prevI_q;
        prevQ_d   = prevQ_q;
        midI_d    = midI_q;
        midQ_d    = midQ_q;
        symv_d    = 1'b0;
        symI_d    = symI_q;
        symQ_d    = symQ_q;
        ted_d     = ted_q;
        ted_upd_d = 1'b0;
        acc_d     = acc_q;

        if (sample_valid) begin
            eta_d = DEC_WIDTH'(w_t);
            if (w_t[DEC_WIDTH]) begin
                dr_d = 1'b1;
                uk_d = w_uk_next;
            end
        end

        // A W update in the same cycle as a sample only affects later samples.
        if (ted_upd_q) begin
            acc_d = DW'(w_acc_new);
            w_d   = DEC_WIDTH'(w_w_new);
        end

        if (interp_valid) begin
            phase_d = ~phase_q;
            if (phase_q == PH_ON) begin
                symv_d  = 1'b1;
                symI_d  = interpI;
                symQ_d  = interpQ;
                prevI_d = interpI;
                prevQ_d = interpQ;
                first_d = 1'b0;
                if (!first_q) begin
                    ted_d     = w_e;
                    ted_upd_d = 1'b1;
                end
            end else begin
                midI_d = interpI;
                midQ_d = interpQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eta_q     <= C_ETA_MAX;
            w_q       <= C_W_NOM;
            dr_q      <= 1'b0;
            uk_q      <= '0;
            phase_q   <= PH_ON;
            first_q   <= 1'b1;
            prevI_q   <= '0;
            prevQ_q   <= '0;
            midI_q    <= '0;
            midQ_q    <= '0;
            symv_q    <= 1'b0;
            symI_q    <= '0;
            symQ_q    <= '0;
            ted_q     <= '0;
            ted_upd_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            eta_q     <= eta_d;
            w_q       <= w_d;
            dr_q      <= dr_d;
            uk_q      <= uk_d;
            phase_q   <= phase_d;
            first_q   <= first_d;
            prevI_q   <= prevI_d;
            prevQ_q   <= prevQ_d;
            midI_q    <= midI_d;
            midQ_q    <= midQ_d;
            symv_q    <= symv_d;
            symI_q    <= symI_d;
            symQ_q    <= symQ_d;
            ted_q     <= ted_d;
            ted_upd_q <= ted_upd_d;
            acc_q     <= acc_d;
        end
    end

`ifdef SYMSYNC_LOCK_DETECT_EN
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic signed [DW-1:0] C_THR = DW'(LOCK_THR);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_q, lock_d;
    logic          w_in_thr;
    assign w_in_thr = (w_e < C_THR) && (w_e > -C_THR);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        lock_d     = lock_q;
        if (w_ted_fire) begin
            if (!w_in_thr)
                lock_cnt_d = '0;
            else if (lock_cnt_q != CW'(LOCK_CNT))
                lock_cnt_d = lock_cnt_q + CW'(1);
            lock_d = (lock_cnt_d == CW'(LOCK_CNT));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{LOCK_THR, LOCK_CNT, w_ted_fire};
    assign lock            = 1'b0;
`endif

    assign data_ready = dr_q;
    assign uk         = uk_q;
    assign sym_valid  = symv_q;
    assign symI       = symI_q;
    assign symQ       = symQ_q;
    assign ted_err    = ted_q;

endmodule
`default_nettype wire

// File: doc/symsync_timing_ctrl.md
Name: symsync_timing_ctrl

Overview:
- Timing-recovery controller for the symbol-synchronisation loop: the producer of `uk` and `data_ready` for the Farrow interpolator, and the consumer of its I/Q outputs.
- Modulo-1 decrementing NCO selects the interpolation instants and the fractional interval.
- Gardner TED plus shift-gain PI loop filter steer the NCO control word.
- Sits between the matched-filter/sample stream and the interpolator, closing the loop around it.

Parameters:
- SYM_WIDTH, 1, sign bits of the fixed-point format
- INT_WIDTH, 1, integer bits
- DEC_WIDTH, 14, fraction bits; DATA_WIDTH = SYM_WIDTH+INT_WIDTH+DEC_WIDTH; 1.0 = 2^DEC_WIDTH
- W_NOM, 2^(DEC_WIDTH-1), nominal NCO step (0.5, i.e. 2 samples/symbol)
- KP_SHIFT, 4, proportional gain = 2^-KP_SHIFT
- KI_SHIFT, 8, integral gain = 2^-KI_SHIFT
- LOCK_THR, 2^(DEC_WIDTH-4), |error| threshold for lock detect
- LOCK_CNT, 32, consecutive in-threshold symbols needed to declare lock

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sample_valid  in  1  one input sample present this cycle
- interp_valid  in  1  interpolator output valid
- interpI  in  DATA_WIDTH  interpolator I output, signed
- interpQ  in  DATA_WIDTH  interpolator Q output, signed
- data_ready  out  1  interpolation strobe to the interpolator
- uk  out  DATA_WIDTH  fractional interval, unsigned in [0,1)
- sym_valid  out  1  on-time symbol valid
- symI  out  DATA_WIDTH  on-time I
- symQ  out  DATA_WIDTH  on-time Q
- ted_err  out  DATA_WIDTH  last TED error, signed
- lock  out  1  timing lock indicator

Behaviour:
- Reset values: eta = 2^DEC_WIDTH-1, W = W_NOM, acc = 0, phase = 0. All outputs are 0. The prev/mid I/Q registers are 0.
- NCO: updates only on a cycle with sample_valid=1.
  - t = eta - W, computed with one guard bit.
  - If t < 0: eta <= t + 2^DEC_WIDTH; next cycle data_ready=1 for exactly one cycle; uk <= min(2*eta_old, 2^DEC_WIDTH-1).
  - Otherwise: eta <= t, data_ready=0.
  - uk holds its value between strobes.
- Latency: data_ready and uk are registered, 1 cycle after the qualifying sample_valid.
- Phase toggle: each interp_valid toggles phase.
  - phase=0 marks an on-time sample. It is registered to symI/symQ with sym_valid=1 one cycle later.
  - phase=1 marks a midpoint sample. It is stored as mid.
- Gardner TED: evaluated on on-time samples, excluding the very first after reset (tracked by a first flag).
  - e = (midI*(curI-prevI) + midQ*(curQ-prevQ)) >>> DEC_WIDTH, arithmetic shift.
  - e is saturated to signed DATA_WIDTH and registered to ted_err.
  - prev <= cur afterwards.
- Loop filter: updates on the cycle after the TED update.
  - acc <= sat(acc + (e >>> KI_SHIFT)).
  - v = sat((e >>> KP_SHIFT) + acc_new).
  - Both saturation limits are ±2^(DEC_WIDTH-2).
  - W <= W_NOM + v.
  - The new W applies from the next sample_valid.
- Simultaneous events: sample_valid and a W update in the same cycle means the NCO uses the old W. interp_valid and sample_valid in the same cycle are both processed independently.
- Wrap-around: eta never leaves [0, 2^DEC_WIDTH). The W clamp guarantees at most one underflow per sample.
- Idle: with sample_valid=0, all state holds. data_ready stays 0.
- Reset mid-operation: all state returns to reset values immediately. The first on-time sample after reset produces no TED update.

Optional Feature:
- Macro: SYMSYNC_LOCK_DETECT_EN.
- Defined:
  - A counter increments on each TED update with |e| < LOCK_THR and clears to 0 otherwise.
  - lock=1 once the counter reaches LOCK_CNT. The counter saturates at LOCK_CNT.
  - lock falls on the first out-of-threshold error.
  - Counter and lock reset to 0.
- Undefined: lock is tied to 0 and no counter is instantiated.

Test Plan:
- Free run: reset, sample_valid every cycle, no interp_valid -> data_ready on every 2nd sample (2nd, 4th, ...), each 1 cycle late; uk=0x3FFE constant; W=8192.
- Gardner update: interp I sequence on=8192, mid=1638, on=-8192, Q=0 -> ted_err=-1638; acc=-7; v=-110; W=8082 effective at the next sample.
- Saturation: drive large persistent error (mid=8191, on=+8191/-8191 alternating) -> acc and v clamp at -4096; W never below 4096; eta stays in range.
- Gated input: sample_valid at 1-in-3 cycles -> strobe spacing and uk sequence identical to the free-run case in sample count; no data_ready when sample_valid=0.
- Reset mid-run: assert rstn=0 between mid and on-time samples -> all outputs 0; the next on-time sample yields sym_valid but no ted_err change.
- Lock (macro defined): 32 consecutive zero-error symbols -> lock=1 on the 32nd update; one error of 2048 -> lock=0 next cycle.
